// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1-to-NUM_CH valid/ready stream demux with broadcast and saturating drop count
module stream_demux_n #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    parameter int CNT_W = 8,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]         drop_cnt
);
    logic [NUM_CH-1:0]        w_hit;
    logic [NUM_CH-1:0]        w_free;
    logic [NUM_CH-1:0]        w_load;
    logic                     w_sel_ok;
    logic                     w_acc;
    logic                     w_drop;
    logic [NUM_CH-1:0]        r_valid;
    logic [NUM_CH*DATA_W-1:0] r_data;
    logic [CNT_W-1:0]         r_cnt;

    // one-hot decode of in_sel; an out-of-range select decodes to all zeros
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_CH; i++) w_hit[i] = in_sel == SEL_W'(i);
    end

    assign w_free   = ~r_valid | out_ready;
    assign w_sel_ok = |w_hit;
    assign in_ready = rst_n && (in_bcast ? &w_free : (!w_sel_ok || |(w_free & w_hit)));
    assign w_acc    = in_valid && in_ready;
    assign w_load   = w_acc ? (in_bcast ? '1 : w_hit) : '0;
    assign w_drop   = w_acc && !in_bcast && !w_sel_ok;

    // per-channel one-entry registers; a load beats a same-cycle drain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_load[i]) begin
                    r_valid[i]                  <= 1'b1;
                    r_data[i*DATA_W +: DATA_W] <= in_data;
                end else if (out_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // saturating count of accepted out-of-range unicasts
    always_ff @(posedge clk) begin
        if (!rst_n) r_cnt <= '0;
        else if (w_drop && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign drop_cnt  = r_cnt;
endmodule

// File: tb/tb_stream_demux_n.sv
// tb_stream_demux_n: directed and modelled checks for 8-channel and 5-channel demux instances
module tb_stream_demux_n;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        v8, rdy8, b8;
    logic [7:0]  d8, ov8, or8, dc8;
    logic [2:0]  s8;
    logic [63:0] od8;
    logic        v5, rdy5, b5;
    logic [7:0]  d5, dc5;
    logic [2:0]  s5;
    logic [4:0]  ov5, or5;
    logic [39:0] od5;
    int          n_chk = 0;
    int          n_err = 0;
    logic [4:0]  m_v, fr;
    logic [7:0]  m_d [5];
    logic [7:0]  m_cnt;
    logic [39:0] m_pack;
    logic        er, acc;

    always #5 clk = ~clk;

    stream_demux_n #(.DATA_W(8), .NUM_CH(8), .CNT_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
        .in_sel(s8), .in_bcast(b8), .out_valid(ov8), .out_ready(or8),
        .out_data(od8), .drop_cnt(dc8)
    );

    stream_demux_n #(.DATA_W(8), .NUM_CH(5), .CNT_W(8)) u5 (
        .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(rdy5), .in_data(d5),
        .in_sel(s5), .in_bcast(b5), .out_valid(ov5), .out_ready(or5),
        .out_data(od5), .drop_cnt(dc5)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        v8 = 1'b0; b8 = 1'b0; d8 = 8'h00; s8 = 3'd0; or8 = 8'h00;
        v5 = 1'b0; b5 = 1'b0; d5 = 8'h00; s5 = 3'd0; or5 = 5'h00;
        m_v = '0; m_cnt = '0;
        for (int i = 0; i < 5; i++) m_d[i] = 8'h00;
        repeat (2) step;
        check("rst_ready", {63'd0, rdy8}, 64'd0);
        check("rst_valid", {56'd0, ov8}, 64'd0);
        check("rst_data", od8, 64'd0);
        check("rst_drop", {56'd0, dc8}, 64'd0);
        rst_n = 1'b1;

        // unicast to channel 3, then blocked re-send, other channel open
        v8 = 1'b1; s8 = 3'd3; d8 = 8'hA5;
        #1 check("t1_ready", {63'd0, rdy8}, 64'd1);
        step;
        check("t1_valid", {56'd0, ov8}, 64'h08);
        check("t1_lane3", {56'd0, od8[31:24]}, 64'hA5);
        d8 = 8'h3C;
        #1 check("t1_busy", {63'd0, rdy8}, 64'd0);
        s8 = 3'd5;
        #1 check("t1_other", {63'd0, rdy8}, 64'd1);
        v8 = 1'b0;

        // same-cycle drain and reload, then 16-word stream
        s8 = 3'd2; d8 = 8'h11; v8 = 1'b1;
        step;
        check("t2_fill", {56'd0, ov8}, 64'h0C);
        or8 = 8'h04; d8 = 8'h22;
        #1 check("t2_ready", {63'd0, rdy8}, 64'd1);
        step;
        check("t2_valid", {56'd0, ov8}, 64'h0C);
        check("t2_lane2", {56'd0, od8[23:16]}, 64'h22);
        for (int k = 0; k < 16; k++) begin
            d8 = 8'h40 + 8'(k);
            #1 check("t2_stream_ready", {63'd0, rdy8}, 64'd1);
            step;
            check("t2_stream_data", {56'd0, od8[23:16]}, 64'h40 + 64'(k));
            check("t2_stream_valid", {56'd0, ov8}, 64'h0C);
        end
        v8 = 1'b0;
        step;
        check("t2_drained", {56'd0, ov8}, 64'h08);
        check("t2_hold", {56'd0, od8[23:16]}, 64'h4F);

        // broadcast blocked by stalled channel 6
        or8 = 8'h00; s8 = 3'd6; d8 = 8'h66; v8 = 1'b1;
        step;
        check("t3_fill6", {56'd0, ov8}, 64'h48);
        b8 = 1'b1; d8 = 8'h5A; or8 = 8'hBF;
        #1 check("t3_blocked", {63'd0, rdy8}, 64'd0);
        or8 = 8'hFF;
        #1 check("t3_release", {63'd0, rdy8}, 64'd1);
        step;
        v8 = 1'b0; b8 = 1'b0; or8 = 8'h00;
        check("t3_valid", {56'd0, ov8}, 64'hFF);
        check("t3_data", od8, 64'h5A5A5A5A5A5A5A5A);
        step;
        check("t3_stall_data", od8, 64'h5A5A5A5A5A5A5A5A);
        check("t3_stall_valid", {56'd0, ov8}, 64'hFF);
        or8 = 8'h01;
        step;
        check("t3_drain0", {56'd0, ov8}, 64'hFE);
        or8 = 8'h00;

        // random traffic on the 5-channel instance against a reference model
        for (int c = 0; c < 2000; c++) begin
            v5  = $urandom_range(0, 3) != 0;
            s5  = 3'($urandom_range(0, 7));
            d5  = 8'($urandom);
            b5  = $urandom_range(0, 9) == 0;
            or5 = 5'($urandom);
            #1;
            fr = ~m_v | or5;
            er = b5 ? &fr : (s5 < 3'd5 ? fr[s5] : 1'b1);
            for (int i = 0; i < 5; i++) m_pack[i*8 +: 8] = m_d[i];
            check("rnd_ready", {63'd0, rdy5}, {63'd0, er});
            check("rnd_valid", {59'd0, ov5}, {59'd0, m_v});
            check("rnd_data", {24'd0, od5}, {24'd0, m_pack});
            check("rnd_drop", {56'd0, dc5}, {56'd0, m_cnt});
            acc = v5 && er;
            for (int i = 0; i < 5; i++) begin
                if (acc && (b5 || 32'(s5) == i)) begin
                    m_v[i] = 1'b1;
                    m_d[i] = d5;
                end else if (or5[i]) begin
                    m_v[i] = 1'b0;
                end
            end
            if (acc && !b5 && s5 >= 3'd5 && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            step;
        end
        v5 = 1'b0; b5 = 1'b0; or5 = 5'h00;

        // fill 0, 1, 4 then pulse reset
        or8 = 8'hFF;
        step;
        or8 = 8'h00; v8 = 1'b1;
        s8 = 3'd0; d8 = 8'h10; step;
        s8 = 3'd1; d8 = 8'h21; step;
        s8 = 3'd4; d8 = 8'h34; step;
        v8 = 1'b0;
        check("t5_filled", {56'd0, ov8}, 64'h13);
        rst_n = 1'b0; v8 = 1'b1; s8 = 3'd0; d8 = 8'h77;
        #1 check("t5_rst_ready8", {63'd0, rdy8}, 64'd0);
        check("t5_rst_ready5", {63'd0, rdy5}, 64'd0);
        step;
        check("t5_valid8", {56'd0, ov8}, 64'd0);
        check("t5_data8", od8, 64'd0);
        check("t5_drop8", {56'd0, dc8}, 64'd0);
        check("t5_valid5", {59'd0, ov5}, 64'd0);
        check("t5_drop5", {56'd0, dc5}, 64'd0);
        rst_n = 1'b1; d8 = 8'h99;
        #1 check("t5_ready_after", {63'd0, rdy8}, 64'd1);
        step;
        v8 = 1'b0;
        check("t5_valid_after", {56'd0, ov8}, 64'h01);
        check("t5_data_after", od8, 64'h99);

        // out-of-range drop saturation on the 5-channel instance
        v5 = 1'b1; s5 = 3'd6; b5 = 1'b0;
        #1;
        for (int i = 0; i < 300; i++) begin
            check("t4_ready", {63'd0, rdy5}, 64'd1);
            step;
            check("t4_valid", {59'd0, ov5}, 64'd0);
            check("t4_drop", {56'd0, dc5}, (i + 1 > 255) ? 64'd255 : 64'(i + 1));
        end
        v5 = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
